// File: rtl/avalon_pio_bank_pkg.sv
`default_nettype none
// ============================================================================
// avalon_pio_pkg : register map, edge-type encoding and byte-lane merge helper
// Revision: 1.0
// ============================================================================
package avalon_pio_pkg;

    localparam logic [1:0] REG_DATA_OUT = 2'd0;
    localparam logic [1:0] REG_DATA_IN  = 2'd1;
    localparam logic [1:0] REG_EDGE_CAP = 2'd2;
    localparam logic [1:0] REG_IRQ_MASK = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = be[b] ? wdata[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_pio_bank_if.sv
`default_nettype none
// ============================================================================
// avalon_pio_bank_if : Avalon-MM slave bus of the PIO bank
// Revision: 1.0
// ============================================================================
interface avalon_pio_bank_if #(
    parameter int AW = 4
);
    logic [AW-1:0] avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [3:0]    avs_byteenable;
    logic [31:0]   avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata
    );
endinterface
`default_nettype wire

// File: rtl/avalon_pio_bank_channel.sv
`default_nettype none
// ============================================================================
// pio_channel : one PIO channel - output reg, input sync, edge capture, mask
// Revision: 1.0
// ============================================================================
module pio_channel
    import avalon_pio_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_data_out,
    input  logic             i_wr_edge_cap,
    input  logic             i_wr_irq_mask,
    input  logic [31:0]      i_wdata,
    input  logic [3:0]       i_be,
    input  logic             i_detect_en,
    input  logic [WIDTH-1:0] i_pin,
    output logic [WIDTH-1:0] o_data_out,
    output logic [WIDTH-1:0] o_data_in,
    output logic [WIDTH-1:0] o_edge_cap,
    output logic [WIDTH-1:0] o_irq_mask,
    output logic             o_irq_req
);
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;

    always_comb begin
        w_edge = '0;
        if (EDGE_TYPE == int'(EDGE_FALL)) begin
            w_edge = ~r_sync[SYNC_STAGES-1] & r_prev;
        end else if (EDGE_TYPE == int'(EDGE_ANY)) begin
            w_edge = r_sync[SYNC_STAGES-1] ^ r_prev;
        end else begin
            w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;
        end
        if (!i_detect_en) begin
            w_edge = '0;
        end
    end

    assign w_clr = i_wr_edge_cap ? WIDTH'(byte_merge(32'h0, i_wdata, i_be)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_prev     <= '0;
            r_data_out <= OUT_RESET;
            r_edge_cap <= '0;
            r_irq_mask <= '0;
        end else begin
            r_sync[0] <= i_pin;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev     <= r_sync[SYNC_STAGES-1];
            // A new edge overrides a simultaneous clear of the same bit
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            if (i_wr_data_out) begin
                r_data_out <= WIDTH'(byte_merge(32'(r_data_out), i_wdata, i_be));
            end
            if (i_wr_irq_mask) begin
                r_irq_mask <= WIDTH'(byte_merge(32'(r_irq_mask), i_wdata, i_be));
            end
        end
    end

    assign o_data_out = r_data_out;
    assign o_data_in  = r_sync[SYNC_STAGES-1];
    assign o_edge_cap = r_edge_cap;
    assign o_irq_mask = r_irq_mask;
    assign o_irq_req  = |(r_edge_cap & r_irq_mask);

endmodule
`default_nettype wire

// File: rtl/avalon_pio_bank.sv
`default_nettype none
// ============================================================================
// avalon_pio_bank : NUM_CH-channel Avalon-MM PIO bank with combined level IRQ
// Revision: 1.0
// ============================================================================
module avalon_pio_bank
    import avalon_pio_pkg::*;
#(
    parameter int               NUM_CH      = 4,
    parameter int               WIDTH       = 16,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    avalon_pio_bank_if.slave        avs,
    input  logic [NUM_CH*WIDTH-1:0] pio_in,
    output logic [NUM_CH*WIDTH-1:0] pio_out,
    output logic                    irq
);
    localparam int AW           = ($clog2(NUM_CH) + 2 > 2) ? $clog2(NUM_CH) + 2 : 2;
    localparam int GUARD_CYCLES = SYNC_STAGES + 1;
    localparam int GW           = $clog2(GUARD_CYCLES + 1);

    logic [AW-1:0]    w_ch;
    logic [1:0]       w_reg;
    logic [GW-1:0]    r_guard;
    logic             w_detect_en;
    logic [31:0]      w_rdata;
    logic [31:0]      r_readdata;
    logic             r_irq;
    logic [NUM_CH-1:0] w_irq_req;
    logic [WIDTH-1:0] w_data_out [NUM_CH];
    logic [WIDTH-1:0] w_data_in  [NUM_CH];
    logic [WIDTH-1:0] w_edge_cap [NUM_CH];
    logic [WIDTH-1:0] w_irq_mask [NUM_CH];

    assign w_ch  = avs.avs_address >> 2;
    assign w_reg = avs.avs_address[1:0];

    // Edge detection stays off until the synchroniser and prev flop hold real pin data
    assign w_detect_en = (r_guard == GW'(GUARD_CYCLES));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_guard <= '0;
        end else if (!w_detect_en) begin
            r_guard <= r_guard + GW'(1);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_sel;
        assign w_sel = avs.avs_write && (w_ch == AW'(c));

        pio_channel #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_TYPE   (EDGE_TYPE),
            .OUT_RESET   (OUT_RESET)
        ) u_channel (
            .clk           (clk_clk),
            .rst_n         (reset_reset_n),
            .i_wr_data_out (w_sel && (w_reg == REG_DATA_OUT)),
            .i_wr_edge_cap (w_sel && (w_reg == REG_EDGE_CAP)),
            .i_wr_irq_mask (w_sel && (w_reg == REG_IRQ_MASK)),
            .i_wdata       (avs.avs_writedata),
            .i_be          (avs.avs_byteenable),
            .i_detect_en   (w_detect_en),
            .i_pin         (pio_in[c*WIDTH +: WIDTH]),
            .o_data_out    (w_data_out[c]),
            .o_data_in     (w_data_in[c]),
            .o_edge_cap    (w_edge_cap[c]),
            .o_irq_mask    (w_irq_mask[c]),
            .o_irq_req     (w_irq_req[c])
        );

        assign pio_out[c*WIDTH +: WIDTH] = w_data_out[c];
    end

    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ch == AW'(c)) begin
                case (w_reg)
                    REG_DATA_OUT: w_rdata = 32'(w_data_out[c]);
                    REG_DATA_IN:  w_rdata = 32'(w_data_in[c]);
                    REG_EDGE_CAP: w_rdata = 32'(w_edge_cap[c]);
                    REG_IRQ_MASK: w_rdata = 32'(w_irq_mask[c]);
                    default:      w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (avs.avs_read) begin
                r_readdata <= w_rdata;
            end
            r_irq <= |w_irq_req;
        end
    end

    assign avs.avs_readdata = r_readdata;
    assign irq              = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_avalon_pio_bank.sv
`default_nettype none
// ============================================================================
// tb_avalon_pio_bank : scoreboard bench for avalon_pio_bank (4 ch x 16 bit)
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_avalon_pio_bank;
    localparam int          NCH     = 4;
    localparam int          SYNC    = 2;
    localparam int          AW      = 5;
    localparam logic [15:0] OUT_RST = 16'h00FF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pio_in;
    logic [63:0] pio_out;
    logic        irq;

    avalon_pio_bank_if #(.AW(AW)) bus ();

    avalon_pio_bank #(
        .NUM_CH      (NCH),
        .WIDTH       (16),
        .SYNC_STAGES (SYNC),
        .EDGE_TYPE   (0),
        .OUT_RESET   (OUT_RST)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .avs           (bus),
        .pio_in        (pio_in),
        .pio_out       (pio_out),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    // Reference model: register contents per channel plus a history of sampled pins
    logic [15:0] m_out  [NCH];
    logic [15:0] m_mask [NCH];
    logic [15:0] m_cap  [NCH];
    logic [63:0] m_hist [$];
    int          m_since;
    logic        m_irq;
    logic [31:0] exp_q  [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_edge();
        logic [63:0] din, prev, rise;
        logic [31:0] bm, rd, wd;
        logic [15:0] clr;
        logic        irq_next;
        int          ch, rg;
        din  = m_hist[SYNC-1];
        prev = m_hist[SYNC];
        rise = (m_since >= SYNC + 1) ? (din & ~prev) : 64'h0;
        ch   = int'(bus.avs_address[4:2]);
        rg   = int'(bus.avs_address[1:0]);
        wd   = bus.avs_writedata;
        bm   = {{8{bus.avs_byteenable[3]}}, {8{bus.avs_byteenable[2]}},
                {8{bus.avs_byteenable[1]}}, {8{bus.avs_byteenable[0]}}};
        irq_next = 1'b0;
        for (int c = 0; c < NCH; c++) irq_next = irq_next | (|(m_cap[c] & m_mask[c]));
        if (bus.avs_read) begin
            rd = 32'h0;
            if (ch < NCH) begin
                case (rg)
                    0: rd = {16'h0, m_out[ch]};
                    1: rd = {16'h0, din[ch*16 +: 16]};
                    2: rd = {16'h0, m_cap[ch]};
                    default: rd = {16'h0, m_mask[ch]};
                endcase
            end
            exp_q.push_back(rd);
        end
        for (int c = 0; c < NCH; c++) begin
            clr = (bus.avs_write && ch == c && rg == 2) ? (wd[15:0] & bm[15:0]) : 16'h0;
            m_cap[c] = (m_cap[c] & ~clr) | rise[c*16 +: 16];
        end
        if (bus.avs_write && ch < NCH) begin
            if (rg == 0) m_out[ch]  = (m_out[ch]  & ~bm[15:0]) | (wd[15:0] & bm[15:0]);
            if (rg == 3) m_mask[ch] = (m_mask[ch] & ~bm[15:0]) | (wd[15:0] & bm[15:0]);
        end
        m_irq = irq_next;
        m_hist.push_front(pio_in);
        void'(m_hist.pop_back());
        m_since++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_out[c]  = OUT_RST;
                m_mask[c] = 16'h0;
                m_cap[c]  = 16'h0;
            end
            m_hist = {};
            for (int s = 0; s <= SYNC; s++) m_hist.push_back(64'h0);
            m_since = 0;
            m_irq   = 1'b0;
            exp_q   = {};
        end else begin
            model_edge();
        end
    end

    // Monitor: compares outputs half a cycle after each active edge
    always @(negedge clk) begin
        if (rst_n === 1'b0) begin
            check("reset_readdata", {32'h0, bus.avs_readdata}, 64'h0);
            check("reset_irq", {63'h0, irq}, 64'h0);
            check("reset_pio_out", pio_out, {4{OUT_RST}});
        end else if (rst_n === 1'b1) begin
            if (exp_q.size() > 0) check("readdata", {32'h0, bus.avs_readdata}, {32'h0, exp_q.pop_front()});
            check("irq", {63'h0, irq}, {63'h0, m_irq});
            check("pio_out", pio_out, {m_out[3], m_out[2], m_out[1], m_out[0]});
        end
    end

    task automatic op(input logic rd, input logic wr, input logic [2:0] ch, input logic [1:0] rg,
                      input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus.avs_read       = rd;
        bus.avs_write      = wr;
        bus.avs_address    = {ch, rg};
        bus.avs_writedata  = d;
        bus.avs_byteenable = be;
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 4'h0);
    endtask

    initial begin
        rst_n              = 1'b0;
        pio_in             = 64'h0;
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b0;
        bus.avs_address    = '0;
        bus.avs_writedata  = 32'h0;
        bus.avs_byteenable = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < NCH; c++) op(1'b1, 1'b0, 3'(c), 2'd0, 32'h0, 4'h0);
        op(1'b0, 1'b1, 3'd2, 2'd0, 32'hDEADBEEF, 4'b0001);
        op(1'b1, 1'b0, 3'd2, 2'd0, 32'h0, 4'h0);

        // Single-cycle pulse on ch1 bit 0 with that bit unmasked, then clear it
        op(1'b0, 1'b1, 3'd1, 2'd3, 32'h1, 4'hF);
        idle(1);
        pio_in[16] = 1'b1;
        idle(1);
        pio_in[16] = 1'b0;
        op(1'b1, 1'b0, 3'd1, 2'd1, 32'h0, 4'h0);
        idle(3);
        op(1'b1, 1'b0, 3'd1, 2'd2, 32'h0, 4'h0);
        op(1'b0, 1'b1, 3'd1, 2'd2, 32'h1, 4'hF);
        idle(3);

        // W1C on ch0 bit 3 landing on the same edge as a fresh rise of that bit
        op(1'b0, 1'b1, 3'd0, 2'd3, 32'h8, 4'hF);
        pio_in[3] = 1'b1;
        idle(4);
        pio_in[3] = 1'b0;
        idle(4);
        idle(1);
        pio_in[3] = 1'b1;
        idle(1);
        op(1'b0, 1'b1, 3'd0, 2'd2, 32'h8, 4'hF);
        op(1'b1, 1'b0, 3'd0, 2'd2, 32'h0, 4'h0);
        idle(2);
        op(1'b0, 1'b1, 3'd0, 2'd3, 32'h0, 4'hF);
        op(1'b1, 1'b0, 3'd0, 2'd2, 32'h0, 4'h0);
        idle(2);

        // Unmapped channel 5
        op(1'b1, 1'b0, 3'd5, 2'd0, 32'h0, 4'h0);
        op(1'b0, 1'b1, 3'd5, 2'd0, 32'hFFFF_FFFF, 4'hF);
        op(1'b1, 1'b0, 3'd5, 2'd1, 32'h0, 4'h0);
        op(1'b0, 1'b1, 3'd1, 2'd1, 32'hFFFF_FFFF, 4'hF);
        idle(2);

        // Reset with a read in flight, pins held high through reset
        op(1'b1, 1'b0, 3'd2, 2'd0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        pio_in = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NCH; c++) op(1'b0, 1'b1, 3'(c), 2'd3, 32'hFFFF, 4'hF);
        idle(10);
        for (int c = 0; c < NCH; c++) op(1'b1, 1'b0, 3'(c), 2'd2, 32'h0, 4'h0);
        idle(1);

        // Randomised traffic with sparse pin activity
        for (int i = 0; i < 400; i++) begin
            op(1'($urandom), 1'($urandom), 3'($urandom_range(0, 5)), 2'($urandom),
               $urandom, 4'($urandom));
            pio_in = pio_in ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
        end
        idle(3);
        check("read_queue_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
